bus_rr_arbiter: RTL and testbench

// - Round-robin arbiter that shares one memory-mapped device port (RAM or test utility) among NrHosts

---
 rtl/bus_arb_pkg.sv | 21 ++
 rtl/bus_arb_id_fifo.sv | 63 ++++++
 rtl/bus_rr_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_bus_rr_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
// Shared types, constants and width helpers for the round-robin bus arbiter.
// Optional perf counters in the top level are enabled with BUS_ARB_PERF_CNT_EN.
package bus_arb_pkg;

    localparam int PerfCntWidth = 32;

    typedef logic [PerfCntWidth-1:0] perf_cnt_t;

    localparam perf_cnt_t PerfCntMax = '1;

    // Index width for n entries, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Width of a host identifier for n hosts.
    function automatic int host_id_width(input int n);
        return idx_width(n);
    endfunction

endpackage

// File: rtl/bus_arb_id_fifo.sv
// In-order FIFO of host IDs for outstanding transactions.
// One entry is pushed per granted request and popped per response.
module bus_arb_id_fifo
    import bus_arb_pkg::*;
#(
    parameter int Depth   = 2,
    parameter int IdWidth = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               push,
    input  logic [IdWidth-1:0] push_id,
    input  logic               pop,
    output logic               full,
    output logic               empty,
    output logic [IdWidth-1:0] head
);

    localparam int PtrWidth = idx_width(Depth);
    localparam int CntWidth = $clog2(Depth + 1);

    logic [IdWidth-1:0]  mem [Depth];
    logic [PtrWidth-1:0] wr_ptr;
    logic [PtrWidth-1:0] rd_ptr;
    logic [CntWidth-1:0] count;
    logic                push_ok;
    logic                pop_ok;

    assign full    = (count == CntWidth'(Depth));
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // Storage write; contents need no reset since count guards reads.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_id;
        end
    end

    // Pointer and occupancy tracking with explicit wrap for any depth.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= (wr_ptr == PtrWidth'(Depth - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= (rd_ptr == PtrWidth'(Depth - 1)) ? '0 : rd_ptr + 1'b1;
            end
            unique case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter sharing one OBI-style device port among NrHosts hosts.
// Grants are zero-latency; responses are routed back via an in-order ID FIFO.
// Define BUS_ARB_PERF_CNT_EN to add per-host grant and stall counters.
module bus_rr_arbiter
    import bus_arb_pkg::*;
#(
    parameter int NrHosts        = 3,
    parameter int DataWidth      = 32,
    parameter int AddrWidth      = 32,
    parameter int MaxOutstanding = 2
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [NrHosts-1:0]                 host_req_i,
    output logic [NrHosts-1:0]                 host_gnt_o,
    input  logic [NrHosts*AddrWidth-1:0]       host_addr_i,
    input  logic [NrHosts-1:0]                 host_we_i,
    input  logic [NrHosts*(DataWidth/8)-1:0]   host_be_i,
    input  logic [NrHosts*DataWidth-1:0]       host_wdata_i,
    output logic [NrHosts-1:0]                 host_rvalid_o,
    output logic [NrHosts*DataWidth-1:0]       host_rdata_o,
    output logic [NrHosts-1:0]                 host_err_o,
    output logic                               dev_req_o,
    input  logic                               dev_gnt_i,
    output logic [AddrWidth-1:0]               dev_addr_o,
    output logic                               dev_we_o,
    output logic [DataWidth/8-1:0]             dev_be_o,
    output logic [DataWidth-1:0]               dev_wdata_o,
    input  logic                               dev_rvalid_i,
    input  logic [DataWidth-1:0]               dev_rdata_i,
    input  logic                               dev_err_i,
    output logic                               proto_err_o
`ifdef BUS_ARB_PERF_CNT_EN
    ,
    output logic [NrHosts*PerfCntWidth-1:0]    perf_gnt_cnt_o,
    output logic [PerfCntWidth-1:0]            perf_stall_cnt_o
`endif
);

    localparam int IdWidth = host_id_width(NrHosts);
    localparam int BeWidth = DataWidth / 8;

    logic [IdWidth-1:0] rr_ptr;
    logic [IdWidth-1:0] winner;
    logic               any_req;
    int                 cand;
    logic               active;
    logic               allow;
    logic               grant;
    logic               fifo_full;
    logic               fifo_empty;
    logic [IdWidth-1:0] fifo_head;
    logic               resp_pop;
    logic               proto_err_q;

    // Outputs stay quiet during reset and for the first cycle after it.
    assign allow = active & ~rst_i;

    // Search for the first requester at or after the round-robin pointer.
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        cand    = 0;
        for (int i = 0; i < NrHosts; i++) begin
            cand = int'(rr_ptr) + i;
            if (cand >= NrHosts) begin
                cand = cand - NrHosts;
            end
            if (!any_req && host_req_i[cand]) begin
                any_req = 1'b1;
                winner  = IdWidth'(cand);
            end
        end
    end

    // A full FIFO blocks the request even if a response pops it this cycle.
    assign dev_req_o = allow & any_req & ~fifo_full;
    assign grant     = dev_req_o & dev_gnt_i;

    assign dev_addr_o  = host_addr_i[winner*AddrWidth +: AddrWidth];
    assign dev_we_o    = host_we_i[winner];
    assign dev_be_o    = host_be_i[winner*BeWidth +: BeWidth];
    assign dev_wdata_o = host_wdata_i[winner*DataWidth +: DataWidth];

    // One-hot grant back to the selected host.
    always_comb begin
        host_gnt_o = '0;
        if (grant) begin
            host_gnt_o[winner] = 1'b1;
        end
    end

    assign resp_pop = dev_rvalid_i & ~fifo_empty;

    // Route the response to the host at the head of the ID FIFO.
    always_comb begin
        host_rvalid_o = '0;
        host_err_o    = '0;
        if (allow && resp_pop) begin
            host_rvalid_o[fifo_head] = 1'b1;
            host_err_o[fifo_head]    = dev_err_i;
        end
    end

    assign host_rdata_o = {NrHosts{dev_rdata_i}};

    bus_arb_id_fifo #(
        .Depth   (MaxOutstanding),
        .IdWidth (IdWidth)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push    (grant),
        .push_id (winner),
        .pop     (resp_pop),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head    (fifo_head)
    );

    // Pointer advances past the granted host; holds when nothing is granted.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr <= '0;
        end else if (grant) begin
            rr_ptr <= (winner == IdWidth'(NrHosts - 1)) ? '0 : winner + 1'b1;
        end
    end

    // Marks the end of the post-reset quiet cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            active <= 1'b0;
        end else begin
            active <= 1'b1;
        end
    end

    // Sticky flag for a response that has no outstanding transaction.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            proto_err_q <= 1'b0;
        end else if (dev_rvalid_i && fifo_empty) begin
            proto_err_q <= 1'b1;
        end
    end

    assign proto_err_o = proto_err_q;

`ifdef BUS_ARB_PERF_CNT_EN
    perf_cnt_t gnt_cnt [NrHosts];
    perf_cnt_t stall_cnt;

    // Saturating per-host grant counters and stall counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NrHosts; i++) begin
                gnt_cnt[i] <= '0;
            end
            stall_cnt <= '0;
        end else begin
            for (int i = 0; i < NrHosts; i++) begin
                if (host_gnt_o[i] && gnt_cnt[i] != PerfCntMax) begin
                    gnt_cnt[i] <= gnt_cnt[i] + 1'b1;
                end
            end
            if ((|host_req_i) && !grant && stall_cnt != PerfCntMax) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

    // Pack the grant counters onto the flat output bus.
    always_comb begin
        perf_gnt_cnt_o = '0;
        for (int i = 0; i < NrHosts; i++) begin
            perf_gnt_cnt_o[i*PerfCntWidth +: PerfCntWidth] = gnt_cnt[i];
        end
    end

    assign perf_stall_cnt_o = stall_cnt;
`endif

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed, table-driven bench for bus_rr_arbiter (3 hosts, 32-bit, depth 2).
module tb_bus_rr_arbiter;

    localparam int NH = 3;

    logic           clk;
    logic           rst;
    logic [NH-1:0]  host_req;
    logic [NH-1:0]  host_gnt;
    logic [NH*32-1:0] host_addr;
    logic [NH-1:0]  host_we;
    logic [NH*4-1:0] host_be;
    logic [NH*32-1:0] host_wdata;
    logic [NH-1:0]  host_rvalid;
    logic [NH*32-1:0] host_rdata;
    logic [NH-1:0]  host_err;
    logic           dev_req;
    logic           dev_gnt;
    logic [31:0]    dev_addr;
    logic           dev_we;
    logic [3:0]     dev_be;
    logic [31:0]    dev_wdata;
    logic           dev_rvalid;
    logic [31:0]    dev_rdata;
    logic           dev_err;
    logic           proto_err;
`ifdef BUS_ARB_PERF_CNT_EN
    logic [NH*32-1:0] perf_gnt_cnt;
    logic [31:0]      perf_stall_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    bus_rr_arbiter dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .host_req_i    (host_req),
        .host_gnt_o    (host_gnt),
        .host_addr_i   (host_addr),
        .host_we_i     (host_we),
        .host_be_i     (host_be),
        .host_wdata_i  (host_wdata),
        .host_rvalid_o (host_rvalid),
        .host_rdata_o  (host_rdata),
        .host_err_o    (host_err),
        .dev_req_o     (dev_req),
        .dev_gnt_i     (dev_gnt),
        .dev_addr_o    (dev_addr),
        .dev_we_o      (dev_we),
        .dev_be_o      (dev_be),
        .dev_wdata_o   (dev_wdata),
        .dev_rvalid_i  (dev_rvalid),
        .dev_rdata_i   (dev_rdata),
        .dev_err_i     (dev_err),
        .proto_err_o   (proto_err)
`ifdef BUS_ARB_PERF_CNT_EN
        ,
        .perf_gnt_cnt_o   (perf_gnt_cnt),
        .perf_stall_cnt_o (perf_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [2:0]  req;
        logic        gnt;
        logic        rv;
        logic        err;
        logic [31:0] rdata;
        logic        exp_dreq;
        int          exp_win;
        logic [2:0]  exp_gnt;
        logic [2:0]  exp_rv;
        logic [2:0]  exp_err;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] addr_of(input int h);
        return 32'h1000_0000 + 32'(h) * 32'h100;
    endfunction

    function automatic logic [31:0] wdata_of(input int h);
        return 32'hA5A5_0000 + 32'(h);
    endfunction

    function automatic logic [3:0] be_of(input int h);
        logic [3:0] one;
        one = 4'b0001;
        return one << h;
    endfunction

    function automatic vec_t mk(input logic r, input logic [2:0] req, input logic g,
                                input logic rv, input logic e, input logic [31:0] rd,
                                input logic edr, input int ew, input logic [2:0] eg,
                                input logic [2:0] erv, input logic [2:0] ee);
        vec_t v;
        v.rst = r; v.req = req; v.gnt = g; v.rv = rv; v.err = e; v.rdata = rd;
        v.exp_dreq = edr; v.exp_win = ew; v.exp_gnt = eg; v.exp_rv = erv; v.exp_err = ee;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle just after the rising edge, check on the falling edge.
    task automatic apply_vec(input vec_t v, input string tag);
        @(posedge clk);
        #1;
        rst        = v.rst;
        host_req   = v.req;
        dev_gnt    = v.gnt;
        dev_rvalid = v.rv;
        dev_err    = v.err;
        dev_rdata  = v.rdata;
        @(negedge clk);
        chk({tag, " dev_req"}, 64'(dev_req), 64'(v.exp_dreq));
        chk({tag, " gnt"}, 64'(host_gnt), 64'(v.exp_gnt));
        chk({tag, " rvalid"}, 64'(host_rvalid), 64'(v.exp_rv));
        chk({tag, " err"}, 64'(host_err), 64'(v.exp_err));
        if (v.exp_dreq) begin
            chk({tag, " dev_addr"}, 64'(dev_addr), 64'(addr_of(v.exp_win)));
            chk({tag, " dev_wdata"}, 64'(dev_wdata), 64'(wdata_of(v.exp_win)));
            chk({tag, " dev_be"}, 64'(dev_be), 64'(be_of(v.exp_win)));
            chk({tag, " dev_we"}, 64'(dev_we), 64'(v.exp_win == 2));
        end
        if (v.exp_rv != 3'b000) begin
            for (int h = 0; h < NH; h++) begin
                chk({tag, " rdata"}, 64'(host_rdata[h*32 +: 32]), 64'(v.rdata));
            end
        end
    endtask

    initial begin
        rst        = 1'b1;
        host_req   = '0;
        dev_gnt    = 1'b0;
        dev_rvalid = 1'b0;
        dev_rdata  = '0;
        dev_err    = 1'b0;
        for (int h = 0; h < NH; h++) begin
            host_addr[h*32 +: 32]  = addr_of(h);
            host_wdata[h*32 +: 32] = wdata_of(h);
            host_be[h*4 +: 4]      = be_of(h);
            host_we[h]             = (h == 2);
        end

        // Reset with activity on inputs, then fairness / error / wrap table.
        vecs.push_back(mk(1, 3'b111, 1, 1, 0, 32'h0,  0, 0, 3'b000, 3'b000, 3'b000));
        vecs.push_back(mk(1, 3'b111, 1, 1, 0, 32'h0,  0, 0, 3'b000, 3'b000, 3'b000));
        vecs.push_back(mk(0, 3'b111, 1, 0, 0, 32'h0,  0, 0, 3'b000, 3'b000, 3'b000));
        vecs.push_back(mk(0, 3'b111, 1, 0, 0, 32'h0,  1, 0, 3'b001, 3'b000, 3'b000));
        vecs.push_back(mk(0, 3'b111, 1, 1, 0, 32'h11, 1, 1, 3'b010, 3'b001, 3'b000));
        vecs.push_back(mk(0, 3'b111, 1, 1, 0, 32'h22, 1, 2, 3'b100, 3'b010, 3'b000));
        vecs.push_back(mk(0, 3'b111, 1, 1, 0, 32'h33, 1, 0, 3'b001, 3'b100, 3'b000));
        vecs.push_back(mk(0, 3'b111, 1, 1, 0, 32'h44, 1, 1, 3'b010, 3'b001, 3'b000));
        vecs.push_back(mk(0, 3'b111, 1, 1, 0, 32'h55, 1, 2, 3'b100, 3'b010, 3'b000));
        vecs.push_back(mk(0, 3'b000, 1, 1, 0, 32'h66, 0, 0, 3'b000, 3'b100, 3'b000));
        vecs.push_back(mk(0, 3'b010, 1, 0, 0, 32'h0,  1, 1, 3'b010, 3'b000, 3'b000));
        vecs.push_back(mk(0, 3'b000, 0, 1, 1, 32'hDEADBEEF, 0, 0, 3'b000, 3'b010, 3'b010));
        vecs.push_back(mk(0, 3'b011, 0, 0, 0, 32'h0,  1, 0, 3'b000, 3'b000, 3'b000));
        vecs.push_back(mk(0, 3'b011, 1, 0, 0, 32'h0,  1, 0, 3'b001, 3'b000, 3'b000));
        vecs.push_back(mk(0, 3'b011, 1, 1, 0, 32'h77, 1, 1, 3'b010, 3'b001, 3'b000));
        vecs.push_back(mk(0, 3'b000, 0, 1, 0, 32'h88, 0, 0, 3'b000, 3'b010, 3'b000));

        foreach (vecs[i]) begin
            apply_vec(vecs[i], $sformatf("table[%0d]", i));
        end
        chk("table proto_err", 64'(proto_err), 64'd0);

        // Single requester: host 2 granted every cycle, pointer wraps to 0.
        for (int k = 0; k < 6; k++) begin
            apply_vec(mk(0, 3'b100, 1, k > 0, 0, 32'h200 + 32'(k), 1, 2, 3'b100,
                         (k > 0) ? 3'b100 : 3'b000, 3'b000), $sformatf("single[%0d]", k));
        end
        apply_vec(mk(0, 3'b111, 0, 1, 0, 32'h2FF, 1, 0, 3'b000, 3'b100, 3'b000), "single wrap");

        // Backpressure: response latency 5, FIFO depth 2, no pass-through on full.
        for (int c = 0; c < 8; c++) begin
            logic rv_c;
            logic dq_c;
            rv_c = (c == 5) || (c == 6) || (c == 7);
            dq_c = (c == 0) || (c == 1) || (c == 6);
            apply_vec(mk(0, (c < 7) ? 3'b001 : 3'b000, 1, rv_c, 0, 32'h300 + 32'(c), dq_c, 0,
                         dq_c ? 3'b001 : 3'b000, rv_c ? 3'b001 : 3'b000, 3'b000),
                      $sformatf("bp[%0d]", c));
        end
        chk("bp proto_err", 64'(proto_err), 64'd0);

        // Protocol error: response with nothing outstanding is dropped, flag sticks.
        apply_vec(mk(0, 3'b000, 0, 1, 1, 32'h99, 0, 0, 3'b000, 3'b000, 3'b000), "proto pulse");
        chk("proto same cycle", 64'(proto_err), 64'd0);
        for (int k = 0; k < 3; k++) begin
            apply_vec(mk(0, 3'b000, 0, 0, 0, 32'h0, 0, 0, 3'b000, 3'b000, 3'b000), "proto idle");
            chk("proto sticky", 64'(proto_err), 64'd1);
        end

        // Reset mid-flight: two outstanding, pointer left at 1.
        apply_vec(mk(0, 3'b001, 1, 0, 0, 32'h0, 1, 0, 3'b001, 3'b000, 3'b000), "mid g0");
        apply_vec(mk(0, 3'b001, 1, 0, 0, 32'h0, 1, 0, 3'b001, 3'b000, 3'b000), "mid g1");
        apply_vec(mk(1, 3'b011, 1, 0, 0, 32'h0, 0, 0, 3'b000, 3'b000, 3'b000), "mid rst");
        apply_vec(mk(0, 3'b011, 1, 0, 0, 32'h0, 0, 0, 3'b000, 3'b000, 3'b000), "mid quiet");
        chk("mid proto cleared", 64'(proto_err), 64'd0);
        apply_vec(mk(0, 3'b011, 1, 0, 0, 32'h0, 1, 0, 3'b001, 3'b000, 3'b000), "mid ptr0");
        apply_vec(mk(0, 3'b011, 1, 0, 0, 32'h0, 1, 1, 3'b010, 3'b000, 3'b000), "mid fifo clr");
        apply_vec(mk(0, 3'b000, 0, 1, 0, 32'h401, 0, 0, 3'b000, 3'b001, 3'b000), "mid resp0");
        apply_vec(mk(0, 3'b000, 0, 1, 0, 32'h402, 0, 0, 3'b000, 3'b010, 3'b000), "mid resp1");
        chk("mid proto before late", 64'(proto_err), 64'd0);
        apply_vec(mk(0, 3'b000, 0, 1, 0, 32'h403, 0, 0, 3'b000, 3'b000, 3'b000), "mid late");
        apply_vec(mk(0, 3'b000, 0, 0, 0, 32'h0, 0, 0, 3'b000, 3'b000, 3'b000), "mid after");
        chk("mid late proto", 64'(proto_err), 64'd1);

`ifdef BUS_ARB_PERF_CNT_EN
        // Counters: 10 grants to host 0, then 3 stalled request cycles.
        apply_vec(mk(1, 3'b000, 0, 0, 0, 32'h0, 0, 0, 3'b000, 3'b000, 3'b000), "perf rst");
        apply_vec(mk(0, 3'b000, 0, 0, 0, 32'h0, 0, 0, 3'b000, 3'b000, 3'b000), "perf quiet");
        for (int k = 0; k < 10; k++) begin
            apply_vec(mk(0, 3'b001, 1, k > 0, 0, 32'h500, 1, 0, 3'b001,
                         (k > 0) ? 3'b001 : 3'b000, 3'b000), "perf gnt");
        end
        for (int k = 0; k < 3; k++) begin
            apply_vec(mk(0, 3'b001, 0, k == 0, 0, 32'h500, 1, 0, 3'b000,
                         (k == 0) ? 3'b001 : 3'b000, 3'b000), "perf stall");
        end
        apply_vec(mk(0, 3'b000, 0, 0, 0, 32'h0, 0, 0, 3'b000, 3'b000, 3'b000), "perf idle");
        chk("perf gnt0", 64'(perf_gnt_cnt[31:0]), 64'd10);
        chk("perf gnt1", 64'(perf_gnt_cnt[63:32]), 64'd0);
        chk("perf stall", 64'(perf_stall_cnt), 64'd3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
